krnl_vadd_rtl_bcast: RTL and testbench

Single-input, multi-output AXI4-Stream broadcaster feeding the vector-add datapath. One upstream stream is registered once and replicated onto C_NUM_CHANNELS downstream channels. Each channel has an independent handshake: a beat is retired per channel as that channel accepts it, and the next input beat is admitted only when every channel has taken, or is taking, the current one. It sits between the memory read master and the per-channel consumers, on the input side of the channel-merging adder.

---
 rtl/krnl_vadd_rtl_pkg.sv | 19 +
 rtl/krnl_vadd_rtl_bcast_slot.sv | 40 ++++
 rtl/krnl_vadd_rtl_bcast.sv | 92 +++++++++
 tb/tb_krnl_vadd_rtl_bcast.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_vadd_rtl_pkg.sv
// -----------------------------------------------------------------------------
// krnl_vadd_rtl_pkg
//
// Shared definitions for the vector-add kernel datapath. The broadcaster and
// the channel-merging adder both use these.
//
// Contents:
//   DATA_WIDTH   - default beat width for every stream in the kernel
//   MAX_CHANNELS - largest supported broadcaster / adder channel count
//   chan_data_t  - packed per-channel data bundle at the default sizes
// -----------------------------------------------------------------------------
package krnl_vadd_rtl_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int MAX_CHANNELS = 16;

    typedef logic [MAX_CHANNELS-1:0][DATA_WIDTH-1:0] chan_data_t;

endpackage

// File: rtl/krnl_vadd_rtl_bcast_slot.sv
// -----------------------------------------------------------------------------
// krnl_vadd_rtl_bcast_slot
//
// Per-channel bookkeeping for the broadcaster. It records whether this channel
// still has to take the word that the top level currently holds.
//
// Ports:
//   aclk     in   clock, rising edge
//   areset_n in   asynchronous active-low reset
//   load     in   top level loads a new word this cycle
//   ready    in   downstream ready of this channel
//   pending  out  channel has not yet taken the held word (drives m_tvalid)
//   owe      out  channel is pending and does not retire this cycle
// -----------------------------------------------------------------------------
module krnl_vadd_rtl_bcast_slot
    import krnl_vadd_rtl_pkg::*;
(
    input  logic aclk,
    input  logic areset_n,
    input  logic load,
    input  logic ready,
    output logic pending,
    output logic owe
);

    assign owe = pending & ~ready;

    // A load in the same cycle as a retire takes priority: the channel has
    // just consumed the old word and immediately owes the new one.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b1;
        end else if (ready) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/krnl_vadd_rtl_bcast.sv
// -----------------------------------------------------------------------------
// krnl_vadd_rtl_bcast
//
// AXI4-Stream broadcaster. The upstream beat is held once and offered to every
// downstream channel. Each channel retires the beat independently. The next
// upstream beat is admitted only when no channel still owes the current one.
//
// Handshake: a transfer happens on a rising edge where tvalid & tready are
// both high. tvalid, tdata and tlast hold stable until that transfer. tready
// is allowed to depend on tvalid. Here s_tready depends combinationally on
// m_tready, which keeps throughput at one beat per cycle.
//
// Parameters:
//   C_DATA_WIDTH   - beat width
//   C_NUM_CHANNELS - number of output channels (1..MAX_CHANNELS)
//   C_CNT_WIDTH    - width of the packet counter (wraps, no saturation)
//
// Ports:
//   aclk, areset_n               clock / async active-low reset
//   s_tvalid, s_tdata, s_tlast   upstream beat
//   s_tready                     upstream ready
//   m_tvalid, m_tdata, m_tlast   per-channel downstream beat
//   m_tready                     per-channel downstream ready
//   pkt_count                    count of accepted tlast beats since reset
// -----------------------------------------------------------------------------
module krnl_vadd_rtl_bcast
    import krnl_vadd_rtl_pkg::*;
#(
    parameter int C_DATA_WIDTH   = DATA_WIDTH,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_CNT_WIDTH    = 32
) (
    input  logic                                         aclk,
    input  logic                                         areset_n,
    input  logic                                         s_tvalid,
    input  logic [C_DATA_WIDTH-1:0]                      s_tdata,
    input  logic                                         s_tlast,
    output logic                                         s_tready,
    output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
    output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
    output logic [C_NUM_CHANNELS-1:0]                    m_tlast,
    input  logic [C_NUM_CHANNELS-1:0]                    m_tready,
    output logic [C_CNT_WIDTH-1:0]                       pkt_count
);

    logic [C_DATA_WIDTH-1:0]   data_q;
    logic                      last_q;
    logic [C_NUM_CHANNELS-1:0] pending;
    logic [C_NUM_CHANNELS-1:0] owe;
    logic                      accept;

    // Blocked only while some channel keeps the held word past this edge.
    assign s_tready = ~(|owe);
    assign accept   = s_tvalid & s_tready;

    genvar i;
    generate
        for (i = 0; i < C_NUM_CHANNELS; i++) begin : g_slot
            krnl_vadd_rtl_bcast_slot u_slot (
                .aclk     (aclk),
                .areset_n (areset_n),
                .load     (accept),
                .ready    (m_tready[i]),
                .pending  (pending[i]),
                .owe      (owe[i])
            );
            assign m_tdata[i] = data_q;
        end
    endgenerate

    assign m_tvalid = pending;
    assign m_tlast  = pending & {C_NUM_CHANNELS{last_q}};

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            data_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            data_q <= s_tdata;
            last_q <= s_tlast;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pkt_count <= '0;
        end else if (accept && s_tlast) begin
            pkt_count <= pkt_count + C_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_krnl_vadd_rtl_bcast.sv
// -----------------------------------------------------------------------------
// tb_krnl_vadd_rtl_bcast
//
// Directed bench for the broadcaster. The main instance uses two 32-bit
// channels. A second instance uses one channel and a 4-bit counter so that
// counter wrap can be reached quickly. Inputs change on the falling edge.
// Outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_krnl_vadd_rtl_bcast;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic areset_n;
    always #5 aclk = ~aclk;

    // ---------------- main DUT (2 channels) ----------------
    logic             s_tvalid;
    logic [31:0]      s_tdata;
    logic             s_tlast;
    logic             s_tready;
    logic [1:0]       m_tvalid;
    logic [1:0][31:0] m_tdata;
    logic [1:0]       m_tlast;
    logic [1:0]       m_tready;
    logic [31:0]      pkt_count;

    krnl_vadd_rtl_bcast #(
        .C_DATA_WIDTH   (32),
        .C_NUM_CHANNELS (2),
        .C_CNT_WIDTH    (32)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .pkt_count (pkt_count)
    );

    // ---------------- wrap DUT (1 channel, 4-bit count) ----------------
    logic            w_s_tvalid;
    logic [7:0]      w_s_tdata;
    logic            w_s_tlast;
    logic            w_s_tready;
    logic [0:0]      w_m_tvalid;
    logic [0:0][7:0] w_m_tdata;
    logic [0:0]      w_m_tlast;
    logic [0:0]      w_m_tready;
    logic [3:0]      w_pkt_count;

    krnl_vadd_rtl_bcast #(
        .C_DATA_WIDTH   (8),
        .C_NUM_CHANNELS (1),
        .C_CNT_WIDTH    (4)
    ) dut_wrap (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .s_tvalid  (w_s_tvalid),
        .s_tdata   (w_s_tdata),
        .s_tlast   (w_s_tlast),
        .s_tready  (w_s_tready),
        .m_tvalid  (w_m_tvalid),
        .m_tdata   (w_m_tdata),
        .m_tlast   (w_m_tlast),
        .m_tready  (w_m_tready),
        .pkt_count (w_pkt_count)
    );

    // ---------------- scoreboard ----------------
    int vectors    = 0;
    int miscompares = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge aclk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [32:0] exp_beat;
        logic        exp_ready;
        int          beat;
        int          budget;
        int          last0;
        int          last1;

        areset_n   = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 2'b00;
        w_s_tvalid = 1'b0;
        w_s_tdata  = '0;
        w_s_tlast  = 1'b0;
        w_m_tready = 1'b1;

        // Reset
        step();
        step();
        areset_n = 1'b1;
        #1;
        check("rst_mvalid", m_tvalid, 2'b00);
        check("rst_mlast", m_tlast, 2'b00);
        check("rst_sready", s_tready, 1);
        check("rst_pkt", pkt_count, 0);
        check("rst_data0", m_tdata[0], 0);

        // Streaming 1..4 with all ready
        m_tready = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            step();
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            s_tlast  = 1'b0;
            #1;
            check("stream_sready", s_tready, 1);
            if (i > 1) begin
                check("stream_valid", m_tvalid, 2'b11);
                check("stream_data0", m_tdata[0], 64'(i - 1));
                check("stream_data1", m_tdata[1], 64'(i - 1));
            end
        end
        step();
        s_tvalid = 1'b0;
        #1;
        check("stream_valid4", m_tvalid, 2'b11);
        check("stream_data0_4", m_tdata[0], 4);
        check("stream_data1_4", m_tdata[1], 4);
        step();
        #1;
        check("stream_idle", m_tvalid, 2'b00);

        // Skewed drain
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5A5A5A5;
        m_tready = 2'b00;
        #1;
        check("skew_sready0", s_tready, 1);
        step();
        s_tdata  = 32'h5A5A0001;
        m_tready = 2'b01;
        #1;
        check("skew_valid_c1", m_tvalid, 2'b11);
        check("skew_sready_c1", s_tready, 0);
        check("skew_data0_c1", m_tdata[0], 32'hA5A5A5A5);
        for (int c = 2; c <= 3; c++) begin
            step();
            #1;
            check("skew_valid_hold", m_tvalid, 2'b10);
            check("skew_data1_hold", m_tdata[1], 32'hA5A5A5A5);
            check("skew_sready_hold", s_tready, 0);
        end
        step();
        m_tready = 2'b10;
        #1;
        check("skew_valid_c4", m_tvalid, 2'b10);
        check("skew_sready_c4", s_tready, 1);
        check("skew_data1_c4", m_tdata[1], 32'hA5A5A5A5);
        step();
        s_tvalid = 1'b0;
        m_tready = 2'b11;
        #1;
        check("skew_valid_c5", m_tvalid, 2'b11);
        check("skew_data0_c5", m_tdata[0], 32'h5A5A0001);
        check("skew_data1_c5", m_tdata[1], 32'h5A5A0001);
        step();
        #1;
        check("skew_idle", m_tvalid, 2'b00);

        // Packets under random per-channel ready
        beat   = 0;
        budget = 0;
        last0  = 0;
        last1  = 0;
        while ((beat < 12 || exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 400) begin
            step();
            s_tvalid = (beat < 12);
            s_tdata  = 32'h100 + 32'(beat);
            s_tlast  = (beat % 4 == 3);
            m_tready = 2'($urandom_range(0, 3));
            #1;
            check("pkt_valid0", m_tvalid[0], exp_q0.size() != 0);
            check("pkt_valid1", m_tvalid[1], exp_q1.size() != 0);
            exp_ready = !((exp_q0.size() != 0 && !m_tready[0]) ||
                          (exp_q1.size() != 0 && !m_tready[1]));
            check("pkt_sready", s_tready, exp_ready);
            if (m_tvalid[0] && m_tready[0] && exp_q0.size() != 0) begin
                exp_beat = exp_q0.pop_front();
                check("pkt_beat0", {m_tlast[0], m_tdata[0]}, exp_beat);
                if (m_tlast[0]) last0++;
            end
            if (m_tvalid[1] && m_tready[1] && exp_q1.size() != 0) begin
                exp_beat = exp_q1.pop_front();
                check("pkt_beat1", {m_tlast[1], m_tdata[1]}, exp_beat);
                if (m_tlast[1]) last1++;
            end
            if (s_tvalid && s_tready) begin
                exp_q0.push_back({s_tlast, s_tdata});
                exp_q1.push_back({s_tlast, s_tdata});
                beat++;
            end
            budget++;
        end
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 2'b00;
        #1;
        check("pkt_timeout", budget < 400, 1);
        check("pkt_count3", pkt_count, 3);
        check("pkt_last0", last0, 3);
        check("pkt_last1", last1, 3);
        check("pkt_drained", m_tvalid, 2'b00);

        // Counter wrap on the 4-bit instance
        for (int k = 0; k < 15; k++) begin
            step();
            w_s_tvalid = 1'b1;
            w_s_tdata  = 8'(k);
            w_s_tlast  = 1'b1;
        end
        step();
        #1;
        check("wrap_count15", w_pkt_count, 15);
        check("wrap_data14", w_m_tdata[0], 14);
        check("wrap_sready", w_s_tready, 1);
        w_s_tdata = 8'd15;
        step();
        w_s_tvalid = 1'b0;
        #1;
        check("wrap_count0", w_pkt_count, 0);
        check("wrap_data15", w_m_tdata[0], 15);
        check("wrap_last", w_m_tlast[0], 1);

        // Async reset while one channel still pending
        step();
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD0001;
        s_tlast  = 1'b0;
        m_tready = 2'b00;
        step();
        s_tvalid = 1'b0;
        m_tready = 2'b01;
        #1;
        check("arst_valid11", m_tvalid, 2'b11);
        step();
        #1;
        check("arst_valid10", m_tvalid, 2'b10);
        check("arst_data1", m_tdata[1], 32'hDEAD0001);
        #2;
        areset_n = 1'b0;
        #1;
        check("arst_mvalid", m_tvalid, 2'b00);
        check("arst_mlast", m_tlast, 2'b00);
        check("arst_pkt", pkt_count, 0);
        check("arst_sready", s_tready, 1);
        step();
        areset_n = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hC0FFEE01;
        m_tready = 2'b11;
        step();
        s_tvalid = 1'b0;
        #1;
        check("arst_after_valid", m_tvalid, 2'b11);
        check("arst_after_data0", m_tdata[0], 32'hC0FFEE01);
        check("arst_after_data1", m_tdata[1], 32'hC0FFEE01);
        check("arst_after_pkt", pkt_count, 0);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
